// File: rtl/key_pkg.sv
// Shared key-code definitions used by the event queue and the calculator core.
package key_pkg;

    localparam int unsigned KEY_WIDTH = 32;

    // Width of a key code able to index every button (at least one bit).
    function automatic int unsigned code_w(input int unsigned width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

    typedef logic [code_w(KEY_WIDTH)-1:0] key_code_t;

endpackage

// File: rtl/lsb_prio_enc.sv
// Lowest-index-first priority encoder: one-hot select, binary index, any.
module lsb_prio_enc
    import key_pkg::*;
#(
    parameter int unsigned WIDTH = KEY_WIDTH,
    localparam int unsigned IDX_W = code_w(WIDTH)
) (
    input  logic [WIDTH-1:0] req_i,
    output logic [WIDTH-1:0] onehot_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             any_o
);

    // Isolate the lowest set bit and report its position.
    always_comb begin
        onehot_o = req_i & (~req_i + WIDTH'(1));
        any_o    = |req_i;
        idx_o    = '0;
        for (int unsigned i = WIDTH; i > 0; i--) begin
            if (req_i[i-1]) begin
                idx_o = IDX_W'(i - 1);
            end
        end
    end

endmodule

// File: rtl/key_event_queue.sv
// Turns debounced button levels into a FIFO of key-press codes.
module key_event_queue
    import key_pkg::*;
#(
    parameter int unsigned WIDTH = KEY_WIDTH,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned CODE_W = code_w(WIDTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WIDTH-1:0]  debounced,
    output logic              key_valid,
    output logic [CODE_W-1:0] key_code,
    input  logic              key_ready,
    output logic              overflow,
    input  logic              clear_overflow
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [WIDTH-1:0]  prev_q;
    logic [WIDTH-1:0]  pending_q, pending_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              overflow_q, overflow_d;
    logic [CODE_W-1:0] mem_q [DEPTH];

    logic [WIDTH-1:0]  rise;
    logic [WIDTH-1:0]  lowest;
    logic [WIDTH-1:0]  grant;
    logic [CODE_W-1:0] grant_idx;
    logic              any_pending;
    logic              push;
    logic              pop;

    lsb_prio_enc #(.WIDTH(WIDTH)) u_enc (
        .req_i    (pending_q),
        .onehot_o (lowest),
        .idx_o    (grant_idx),
        .any_o    (any_pending)
    );

    // Grant, push/pop decisions and next-state for pending, pointers, count, overflow.
    always_comb begin
        rise       = debounced & ~prev_q;
        // A full FIFO never accepts a push, even if it pops in the same cycle.
        grant      = (count_q < DEPTH_C) ? lowest : '0;
        push       = (count_q < DEPTH_C) && any_pending;
        pop        = (count_q != '0) && key_ready;
        pending_d  = (pending_q & ~grant) | rise;
        wr_ptr_d   = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d   = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d    = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        overflow_d = overflow_q;
        if (|(rise & pending_q & ~grant)) begin
            overflow_d = 1'b1;
        end else if (clear_overflow) begin
            overflow_d = 1'b0;
        end
    end

    // Control state register with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_q     <= '0;
            pending_q  <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            prev_q     <= debounced;
            pending_q  <= pending_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // FIFO storage; contents are qualified by count, so no reset is needed.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= grant_idx;
        end
    end

    // Show-ahead output of the oldest entry.
    always_comb begin
        key_valid = (count_q != '0);
        key_code  = mem_q[rd_ptr_q];
        overflow  = overflow_q;
    end

endmodule

// File: tb/tb_key_event_queue.sv
// Randomized and directed bench for key_event_queue against a queue-based reference model.
module tb_key_event_queue;

    localparam int W = 32;
    localparam int D = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] debounced;
    logic         key_valid;
    logic [4:0]   key_code;
    logic         key_ready;
    logic         overflow;
    logic         clear_overflow;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model state: previous levels, pending presses, queued codes, sticky flag.
    logic [W-1:0] m_prev;
    bit           m_pend [W];
    int           m_q [$];
    bit           m_ovf;
    int           popped [$];

    key_event_queue #(.WIDTH(W), .DEPTH(D)) dut (
        .clk            (clk),
        .rst            (rst),
        .debounced      (debounced),
        .key_valid      (key_valid),
        .key_code       (key_code),
        .key_ready      (key_ready),
        .overflow       (overflow),
        .clear_overflow (clear_overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_prev = '0;
        foreach (m_pend[i]) m_pend[i] = 1'b0;
        m_q.delete();
        m_ovf = 1'b0;
    endtask

    // One clock of the specified behaviour, given the inputs applied for that cycle.
    task automatic model_step(input logic [W-1:0] d, input bit r, input bit c, input bit rs);
        int g;
        bit lost;
        if (rs) begin
            model_reset();
            return;
        end
        g = -1;
        if (m_q.size() < D) begin
            for (int i = 0; i < W; i++) begin
                if (m_pend[i] && g < 0) g = i;
            end
        end
        lost = 1'b0;
        for (int i = 0; i < W; i++) begin
            if (d[i] && !m_prev[i] && m_pend[i] && i != g) lost = 1'b1;
        end
        if (r && m_q.size() > 0) void'(m_q.pop_front());
        if (g >= 0) begin
            m_q.push_back(g);
            m_pend[g] = 1'b0;
        end
        for (int i = 0; i < W; i++) begin
            if (d[i] && !m_prev[i]) m_pend[i] = 1'b1;
        end
        if (lost) m_ovf = 1'b1;
        else if (c) m_ovf = 1'b0;
        m_prev = d;
    endtask

    // Check outputs against the model, then apply the next cycle's inputs.
    task automatic cyc(input logic [W-1:0] d, input bit r, input bit c, input bit rs = 1'b0);
        @(negedge clk);
        chk("valid", key_valid, m_q.size() != 0);
        if (m_q.size() != 0) chk("code", key_code, m_q[0]);
        chk("overflow", overflow, m_ovf);
        if (key_valid && r && !rs) popped.push_back(int'(key_code));
        rst            = rs;
        debounced      = d;
        key_ready      = r;
        clear_overflow = c;
        model_step(d, r, c, rs);
    endtask

    function automatic int count_code(input int code, input int from);
        int n = 0;
        for (int i = from; i < popped.size(); i++) begin
            if (popped[i] == code) n++;
        end
        return n;
    endfunction

    initial begin
        logic [W-1:0] lv;
        int mark;

        rst = 1'b1; debounced = '0; key_ready = 1'b0; clear_overflow = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("reset_valid", key_valid, 1'b0);
        chk("reset_overflow", overflow, 1'b0);
        cyc('0, 1'b0, 1'b0, 1'b1);
        repeat (3) cyc('0, 1'b1, 1'b0);

        // Single press of bit 5 with the consumer ready, then release.
        mark = popped.size();
        lv = 32'h20;
        repeat (4) cyc(lv, 1'b1, 1'b0);
        repeat (3) cyc('0, 1'b1, 1'b0);
        chk("single_count", popped.size() - mark, 1);
        chk("single_code5", count_code(5, mark), 1);

        // Simultaneous presses of bits 3, 0, 17 must come out 0, 3, 17.
        mark = popped.size();
        lv = (32'h1 << 3) | 32'h1 | (32'h1 << 17);
        repeat (5) cyc(lv, 1'b0, 1'b0);
        chk("simul_head", key_code, 0);
        repeat (4) cyc(lv, 1'b1, 1'b0);
        cyc('0, 1'b1, 1'b0);
        chk("simul_n", popped.size() - mark, 3);
        if (popped.size() - mark == 3) begin
            chk("simul_0", popped[mark], 0);
            chk("simul_1", popped[mark+1], 3);
            chk("simul_2", popped[mark+2], 17);
        end

        // Full FIFO: six presses, four queued; a pop frees a slot for the next cycle.
        lv = 32'h3F << 20;
        repeat (8) cyc(lv, 1'b0, 1'b0);
        chk("full_valid", key_valid, 1'b1);
        chk("full_head", key_code, 20);
        cyc(lv, 1'b1, 1'b0);
        repeat (3) cyc(lv, 1'b0, 1'b0);
        repeat (10) cyc('0, 1'b1, 1'b0);
        chk("full_no_ovf", overflow, 1'b0);

        // Lost press: bit 2 pending behind a full FIFO, released and pressed again.
        mark = popped.size();
        lv = 32'hF << 8;
        repeat (6) cyc(lv, 1'b0, 1'b0);
        cyc(lv | 32'h4, 1'b0, 1'b0);
        cyc(lv, 1'b0, 1'b0);
        cyc(lv | 32'h4, 1'b0, 1'b0);
        cyc(lv | 32'h4, 1'b0, 1'b0);
        chk("lost_ovf_set", overflow, 1'b1);
        repeat (10) cyc('0, 1'b1, 1'b0);
        chk("lost_once", count_code(2, mark), 1);
        cyc('0, 1'b0, 1'b1);
        cyc('0, 1'b0, 1'b0);
        chk("ovf_cleared", overflow, 1'b0);
        repeat (6) cyc(lv, 1'b0, 1'b0);
        cyc(lv | 32'h8, 1'b0, 1'b0);
        cyc(lv, 1'b0, 1'b0);
        cyc(lv | 32'h8, 1'b0, 1'b1);
        cyc(lv | 32'h8, 1'b0, 1'b0);
        chk("set_beats_clear", overflow, 1'b1);
        repeat (10) cyc('0, 1'b1, 1'b1);

        // Wrap-around: 20 distinct presses with key_ready toggling every cycle.
        mark = popped.size();
        for (int i = 0; i < 20; i++) begin
            cyc(32'h1 << i, 1'b1, 1'b0);
            cyc('0, 1'b0, 1'b0);
        end
        for (int i = 0; i < 30; i++) cyc('0, (i % 2) == 0, 1'b0);
        chk("wrap_n", popped.size() - mark, 20);
        if (popped.size() - mark == 20) begin
            for (int i = 0; i < 20; i++) chk("wrap_order", popped[mark+i], i);
        end

        // Asynchronous reset with three entries queued, bit 4 held through it.
        lv = 32'h70;
        repeat (6) cyc(lv, 1'b0, 1'b0);
        chk("pre_reset_valid", key_valid, 1'b1);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("async_valid", key_valid, 1'b0);
        chk("async_overflow", overflow, 1'b0);
        model_reset();
        cyc(32'h10, 1'b0, 1'b0, 1'b1);
        mark = popped.size();
        repeat (5) cyc(32'h10, 1'b1, 1'b0);
        cyc('0, 1'b1, 1'b0);
        chk("post_reset_n", popped.size() - mark, 1);
        chk("post_reset_code4", count_code(4, mark), 1);

        // Randomized stress on the low buttons to provoke duplicates and back-pressure.
        lv = '0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 2) == 0) lv[$urandom_range(0, 7)] ^= 1'b1;
            cyc(lv, $urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0);
        end
        repeat (20) cyc('0, 1'b1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
